// File: rtl/button_event_debouncer.sv
// Multi-channel push-button front end: synchronise, debounce, emit press/release pulses
// and serialise every accepted transition into a small event FIFO read as a stream.
module button_event_debouncer #(
    parameter int NUM_CHANNELS    = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int ACTIVE_LOW      = 1,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                    clock,
    input  logic                    aresetn,
    input  logic [NUM_CHANNELS-1:0] button_in,
    output logic [NUM_CHANNELS-1:0] level_out,
    output logic [NUM_CHANNELS-1:0] press_pulse,
    output logic [NUM_CHANNELS-1:0] release_pulse,
    output logic [7:0]              event_tdata,
    output logic                    event_tvalid,
    input  logic                    event_tready,
    output logic                    overflow,
    input  logic                    overflow_clear
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic            IDLE_RAW = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CHANNELS-1:0] pressedSync;

    logic [CW-1:0]           cnt_q [NUM_CHANNELS];
    logic [CW-1:0]           cnt_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] level_q, level_d;
    logic [NUM_CHANNELS-1:0] press_q, press_d;
    logic [NUM_CHANNELS-1:0] release_q, release_d;

    logic [NUM_CHANNELS-1:0] pending_q, pending_d;
    logic [NUM_CHANNELS-1:0] pendType_q, pendType_d;
    logic                    overflow_q, overflow_d;
    logic                    eventLost;

    logic                    grantFound;
    logic                    grantType;
    logic [NUM_CHANNELS-1:0] grantVec;
    logic [6:0]              grantIdx;
    logic [7:0]              pushData;

    logic [7:0]              mem_q [FIFO_DEPTH];
    logic [AW:0]             wrPtr_q, wrPtr_d;
    logic [AW:0]             rdPtr_q, rdPtr_d;
    logic [7:0]              tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    fifoEmpty, fifoFull;
    logic                    doPush, doPop;

    // Synchroniser resets to the idle pin level so no press appears after reset release.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= {NUM_CHANNELS{IDLE_RAW}};
            end
        end else begin
            sync_q[0] <= button_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign pressedSync = sync_q[SYNC_STAGES-1] ^ {NUM_CHANNELS{IDLE_RAW}};

    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            cnt_d[ch] = '0;
            if (pressedSync[ch] != level_q[ch]) begin
                if (cnt_q[ch] == CNT_LAST) begin
                    level_d[ch]   = pressedSync[ch];
                    press_d[ch]   = pressedSync[ch];
                    release_d[ch] = !pressedSync[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        grantFound = 1'b0;
        grantVec   = '0;
        grantIdx   = '0;
        grantType  = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (pending_q[i] && !grantFound) begin
                grantFound  = 1'b1;
                grantVec[i] = 1'b1;
                grantIdx    = 7'(i);
                grantType   = pendType_q[i];
            end
        end
    end

    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPop     = !fifoEmpty && event_tready;
    assign doPush    = grantFound && (!fifoFull || doPop);
    assign pushData  = {grantType, grantIdx};

    // An event is only lost when a channel still holds an unpushed event at its next pulse.
    always_comb begin
        pending_d  = pending_q;
        pendType_d = pendType_q;
        eventLost  = 1'b0;
        if (doPush) begin
            pending_d = pending_q & ~grantVec;
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (press_d[i] || release_d[i]) begin
                if (pending_d[i]) begin
                    eventLost = 1'b1;
                end
                pending_d[i]  = 1'b1;
                pendType_d[i] = press_d[i];
            end
        end
        overflow_d = overflow_q;
        if (overflow_clear) begin
            overflow_d = 1'b0;
        end
        if (eventLost) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                cnt_q[ch] <= '0;
            end
            level_q    <= '0;
            press_q    <= '0;
            release_q  <= '0;
            pending_q  <= '0;
            pendType_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            pending_q  <= pending_d;
            pendType_q <= pendType_d;
            overflow_q <= overflow_d;
        end
    end

    // Next head is precomputed so the stream outputs come straight from flops.
    always_comb begin
        wrPtr_d  = wrPtr_q + {{AW{1'b0}}, doPush};
        rdPtr_d  = rdPtr_q + {{AW{1'b0}}, doPop};
        tvalid_d = (wrPtr_d != rdPtr_d);
        if (doPush && (wrPtr_q[AW-1:0] == rdPtr_d[AW-1:0])) begin
            tdata_d = pushData;
        end else begin
            tdata_d = mem_q[rdPtr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                mem_q[e] <= '0;
            end
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q[AW-1:0]] <= pushData;
            end
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign level_out     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign event_tdata   = tdata_q;
    assign event_tvalid  = tvalid_q;
    assign overflow      = overflow_q;

endmodule
